// File: rtl/dds_lag_pkg.sv
// Shared definitions for the DDS/channelizer lag checker: FSM states,
// status-word bit positions, the marker channel and the status packer.
package dds_lag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_REF,
        ST_COUNT,
        ST_DONE
    } state_e;

    // Status word bit positions
    localparam int DONE_BIT  = 31;
    localparam int TO_BIT    = 30;
    localparam int REF_BIT   = 29;
    localparam int SNAPV_BIT = 28;
    localparam int CH_LSB    = 16;
    localparam int LAG_LSB   = 0;

    // Channel index that marks the start of a channel frame on both streams
    localparam int MARK_CH = 0;

    // Assemble a completed status word; bits [27:24] are always zero.
    function automatic logic [31:0] pack_status(
        input logic        timeout,
        input logic        ref_seen,
        input logic        snap_v,
        input logic [7:0]  ch,
        input logic [15:0] lag
    );
        logic [31:0] w;
        w                  = '0;
        w[DONE_BIT]        = 1'b1;
        w[TO_BIT]          = timeout;
        w[REF_BIT]         = ref_seen;
        w[SNAPV_BIT]       = snap_v;
        w[CH_LSB +: 8]     = ch;
        w[LAG_LSB +: 16]   = lag;
        return w;
    endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Registered rising-edge detector for the software arm level.
// A level that is already high when reset releases is not treated as an
// edge: the detector first observes one post-reset sample before it can fire,
// so software must drop the level for a cycle to start a new measurement.
module edge_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;
    logic primed_q;

    // Track the previous level and whether a valid previous sample exists
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q      <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            d_q      <= d_i;
            primed_q <= 1'b1;
        end
    end

    assign rise_o = d_i & ~d_q & primed_q;

endmodule

// File: rtl/dds_lag_checker.sv
// Measures the cycle lag from the channelizer's channel-0 marker to the DDS
// stream's channel-0 marker after a software arm, and snapshots the DDS
// channel present at the reference marker. The 32-bit status word feeds a
// software-readable register and only changes on arm or on entering DONE,
// so an asynchronous read always sees a coherent set of fields.
module dds_lag_checker
    import dds_lag_pkg::*;
#(
    parameter int CH_W  = 8,
    parameter int LAG_W = 16
) (
    input  logic            user_clk,
    input  logic            user_rst_n,
    input  logic            arm,
    input  logic [CH_W-1:0] ref_ch,
    input  logic            ref_valid,
    input  logic [CH_W-1:0] dds_ch,
    input  logic            dds_valid,
    output logic [31:0]     status,
    output logic            busy
);

    localparam logic [LAG_W-1:0] CNT_MAX = {LAG_W{1'b1}};

    state_e            state_q;
    logic [LAG_W-1:0]  cnt_q;
    logic [CH_W-1:0]   snap_ch_q;
    logic              snap_v_q;
    logic [31:0]       status_q;
    logic              busy_q;

    logic              arm_rise;
    logic              ref_hit;
    logic              dds_hit;
    logic              cnt_at_max;
    logic [LAG_W:0]    lag_sum;
    logic [LAG_W-1:0]  lag_sat;

    edge_rise_det u_arm_edge (
        .clk    (user_clk),
        .rst_n  (user_rst_n),
        .d_i    (arm),
        .rise_o (arm_rise)
    );

    assign ref_hit    = ref_valid && (ref_ch == CH_W'(MARK_CH));
    assign dds_hit    = dds_valid && (dds_ch == CH_W'(MARK_CH));
    assign cnt_at_max = (cnt_q == CNT_MAX);

    // Lag is counted from the reference marker, so the DDS marker one cycle
    // later reports 1; the extra carry bit lets the result saturate.
    assign lag_sum = {1'b0, cnt_q} + {{LAG_W{1'b0}}, 1'b1};
    assign lag_sat = lag_sum[LAG_W] ? CNT_MAX : lag_sum[LAG_W-1:0];

    // Measurement FSM; status and busy are registered alongside the state
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            snap_ch_q <= '0;
            snap_v_q  <= 1'b0;
            status_q  <= '0;
            busy_q    <= 1'b0;
        end else if (arm_rise) begin
            // NOTE: non-blocking assignments keep every branch reading the
            // pre-edge register values, so arm can safely override all events.
            state_q   <= ST_WAIT_REF;
            cnt_q     <= '0;
            snap_ch_q <= '0;
            snap_v_q  <= 1'b0;
            status_q  <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_WAIT_REF: begin
                    if (ref_hit) begin
                        snap_ch_q <= dds_ch;
                        snap_v_q  <= dds_valid;
                        cnt_q     <= '0;
                        if (dds_hit) begin
                            state_q  <= ST_DONE;
                            busy_q   <= 1'b0;
                            status_q <= pack_status(1'b0, 1'b1, 1'b1,
                                                    8'(dds_ch), 16'd0);
                        end else begin
                            state_q <= ST_COUNT;
                        end
                    end else if (cnt_at_max) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        status_q <= pack_status(1'b1, 1'b0, 1'b0,
                                                8'd0, 16'(CNT_MAX));
                    end else begin
                        cnt_q <= cnt_q + LAG_W'(1);
                    end
                end

                ST_COUNT: begin
                    // A marker on the final count still wins over timeout
                    if (dds_hit) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        status_q <= pack_status(1'b0, 1'b1, snap_v_q,
                                                8'(snap_ch_q), 16'(lag_sat));
                    end else if (cnt_at_max) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        status_q <= pack_status(1'b1, 1'b1, snap_v_q,
                                                8'(snap_ch_q), 16'(CNT_MAX));
                    end else begin
                        cnt_q <= cnt_q + LAG_W'(1);
                    end
                end

                // IDLE and DONE hold the result until the next arm edge
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign status = status_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_dds_lag_checker.sv
// Bench for dds_lag_checker: a vector table of complete measurements plus
// hand-written sequences for timeout, re-arm and asynchronous reset.
// A narrow lag counter keeps the timeout runs short.
module tb_dds_lag_checker;

    localparam int CH_W  = 8;
    localparam int LAG_W = 10;
    localparam int LMAX  = (1 << LAG_W) - 1;

    typedef struct {
        int          ref_delay;
        logic [7:0]  snap_ch;
        logic        snap_v;
        int          gap;
        logic [31:0] exp_status;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            arm;
    logic [CH_W-1:0] ref_ch;
    logic            ref_valid;
    logic [CH_W-1:0] dds_ch;
    logic            dds_valid;
    logic [31:0]     status;
    logic            busy;

    int n_pass;
    int n_total;
    logic [31:0] exp_q[$];
    vec_t vecs[7];

    dds_lag_checker #(
        .CH_W  (CH_W),
        .LAG_W (LAG_W)
    ) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .arm        (arm),
        .ref_ch     (ref_ch),
        .ref_valid  (ref_valid),
        .dds_ch     (dds_ch),
        .dds_valid  (dds_valid),
        .status     (status),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: run still active, got no summary, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ref_valid = 1'b0;
        ref_ch    = '0;
        dds_valid = 1'b0;
        dds_ch    = '0;
    endtask

    // Arm edge; any previous result must be cleared and busy raised
    task automatic arm_start(input string name);
        arm = 1'b0;
        tick();
        arm = 1'b1;
        tick();
        check({name, "_arm_status"}, status, 32'h0);
        check({name, "_arm_busy"}, 32'(busy), 32'd1);
    endtask

    // Traffic that must not end WAIT_REF: non-zero ref channels, stray dds ch0
    task automatic noise_wait_ref(input int n);
        for (int i = 0; i < n; i++) begin
            ref_valid = (i % 2 == 0);
            ref_ch    = (i % 2 == 0) ? 8'(1 + i % 9) : 8'h00;
            dds_valid = 1'b1;
            dds_ch    = 8'h00;
            tick();
        end
        set_idle();
    endtask

    // Traffic that must not end COUNT: repeated ref markers, non-zero dds
    // channels, and an unqualified dds ch0
    task automatic noise_count(input int n);
        for (int i = 0; i < n; i++) begin
            ref_valid = (i % 3 == 0);
            ref_ch    = 8'h00;
            dds_valid = (i % 4 != 1);
            dds_ch    = (i % 4 == 1) ? 8'h00 : 8'(1 + i % 200);
            tick();
        end
        set_idle();
    endtask

    task automatic ref_mark(input logic [7:0] ch, input logic v);
        ref_valid = 1'b1;
        ref_ch    = 8'h00;
        dds_valid = v;
        dds_ch    = ch;
        tick();
        set_idle();
    endtask

    task automatic dds_mark();
        ref_valid = 1'b0;
        dds_valid = 1'b1;
        dds_ch    = 8'h00;
        tick();
        set_idle();
    endtask

    // Wait up to bound cycles for done, then pop and compare the result
    task automatic wait_done(input int bound, input string name);
        int n;
        logic [31:0] exp;
        n = 0;
        while (status[31] !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check({name, "_done"}, 32'(status[31]), 32'd1);
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check({name, "_status"}, status, exp);
        end
        check({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_q.push_back(v.exp_status);
        arm_start(name);
        noise_wait_ref(v.ref_delay);
        ref_mark(v.snap_ch, v.snap_v);
        if (v.gap > 0) begin
            noise_count(v.gap - 1);
            check({name, "_busy_count"}, 32'(busy), 32'd1);
            dds_mark();
        end
        wait_done(0, name);
    endtask

    initial begin
        vec_t fresh;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        arm     = 1'b0;
        set_idle();

        // {ref_delay, snap_ch, snap_v, gap, expected status}
        vecs[0] = '{3,  8'h7C, 1'b1, 5,        32'hB07C_0005};
        vecs[1] = '{0,  8'h00, 1'b1, 0,        32'hB000_0000};
        vecs[2] = '{2,  8'h05, 1'b0, 1,        32'hA005_0001};
        vecs[3] = '{10, 8'hFF, 1'b1, 300,      32'hB0FF_012C};
        vecs[4] = '{1,  8'h00, 1'b0, 2,        32'hA000_0002};
        vecs[5] = '{4,  8'h80, 1'b1, LMAX,     32'hB080_03FF};
        vecs[6] = '{1,  8'h11, 1'b1, LMAX + 1, 32'hB011_03FF};

        #23;
        check("reset_status", status, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        #4 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // No reference marker at all
        exp_q.push_back(32'hC000_0000 | 32'(LMAX));
        arm_start("to_ref");
        wait_done(LMAX + 20, "to_ref");

        // Reference marker seen with dds_valid low, no dds marker afterwards
        exp_q.push_back(32'hE000_0000 | 32'(LMAX));
        arm_start("to_dds");
        ref_mark(8'h00, 1'b0);
        wait_done(LMAX + 20, "to_dds");

        // Re-arm in COUNT on the same edge as a dds marker
        arm_start("rearm");
        ref_mark(8'h44, 1'b1);
        noise_count(3);
        arm = 1'b0;
        noise_count(2);
        arm = 1'b1;
        dds_mark();
        check("rearm_status", status, 32'h0);
        check("rearm_busy", 32'(busy), 32'd1);
        exp_q.push_back(32'hB042_0007);
        noise_wait_ref(2);
        ref_mark(8'h42, 1'b1);
        noise_count(6);
        dds_mark();
        wait_done(0, "rearm_fresh");

        // Asynchronous reset in the middle of COUNT, arm left high
        arm_start("rst");
        ref_mark(8'h33, 1'b1);
        noise_count(4);
        check("rst_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_status", status, 32'h0);
        check("rst_async_busy", 32'(busy), 32'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ref_mark(8'h00, 1'b1);
        noise_count(3);
        check("rst_held_arm_status", status, 32'h0);
        check("rst_held_arm_busy", 32'(busy), 32'd0);

        fresh = '{2, 8'h21, 1'b1, 3, 32'hB021_0003};
        run_vec(fresh, "rst_fresh");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
